// File: rtl/wb_fifo_device.sv
// ============================================================================
// Module      : wb_fifo_device
// Description : Wishbone B4 pipelined device; writes push into a FIFO that
//               drains on a ready/valid stream, reads return the fill level.
//               Optional macro WB_DEV_ERR_ON_FULL_EN: a write to a full FIFO
//               terminates with err_o instead of rty_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo_device #(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    output logic [DAT_WIDTH-1:0] dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o,
    output logic                 stall_o,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DAT_WIDTH-1:0] m_data
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [DAT_WIDTH-1:0] r_mem_q [0:DEPTH-1];

    logic [c_PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_LVL_W-1:0]   r_level_q,  w_level_d;
    logic                 r_stall_q,  w_stall_d;
    logic                 r_ack_q,    w_ack_d;
    logic                 r_err_q,    w_err_d;
    logic                 r_rty_q,    w_rty_d;
    logic [DAT_WIDTH-1:0] r_dat_q,    w_dat_d;

    logic w_accept;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_full_resp;

    always_comb begin
        w_accept    = cyc_i & stb_i & ~r_stall_q;
        // Full is judged on the registered level: a same-cycle pop cannot rescue a write
        w_full      = (r_level_q == c_LVL_W'(DEPTH));
        w_push      = w_accept & we_i & ~w_full;
        w_pop       = (r_level_q != '0) & m_ready;
        w_full_resp = w_accept & we_i & w_full;

        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_level_d   = r_level_q;
        w_stall_d   = 1'b0;
        w_dat_d     = r_dat_q;

        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_level_d = r_level_q + c_LVL_W'(1);
            2'b01:   w_level_d = r_level_q - c_LVL_W'(1);
            default: w_level_d = r_level_q;
        endcase

        w_ack_d = w_accept & (~we_i | ~w_full);
`ifdef WB_DEV_ERR_ON_FULL_EN
        w_err_d = w_full_resp;
        w_rty_d = 1'b0;
`else
        w_err_d = 1'b0;
        w_rty_d = w_full_resp;
`endif

        if (w_accept & ~we_i) begin
            w_dat_d = DAT_WIDTH'(r_level_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
            r_stall_q  <= 1'b1;
            r_ack_q    <= 1'b0;
            r_err_q    <= 1'b0;
            r_rty_q    <= 1'b0;
            r_dat_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
            r_stall_q  <= w_stall_d;
            r_ack_q    <= w_ack_d;
            r_err_q    <= w_err_d;
            r_rty_q    <= w_rty_d;
            r_dat_q    <= w_dat_d;
        end
    end

    // Storage needs no reset; validity is tracked by the level and pointers
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= dat_i;
        end
    end

    // A master that drops cyc_i in the response cycle has aborted; mask the termination
    assign ack_o   = r_ack_q & cyc_i;
    assign err_o   = r_err_q & cyc_i;
    assign rty_o   = r_rty_q & cyc_i;
    assign stall_o = r_stall_q;
    assign dat_o   = r_dat_q;
    assign m_valid = (r_level_q != '0);
    assign m_data  = r_mem_q[r_rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_wb_fifo_device.sv
// ============================================================================
// Module      : tb_wb_fifo_device
// Description : Directed self-checking bench for wb_fifo_device.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_fifo_device;

    localparam int DAT_WIDTH = 8;
    localparam int DEPTH     = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 cyc_i = 1'b0;
    logic                 stb_i = 1'b0;
    logic                 we_i  = 1'b0;
    logic [DAT_WIDTH-1:0] dat_i = '0;
    logic [DAT_WIDTH-1:0] dat_o;
    logic                 ack_o;
    logic                 err_o;
    logic                 rty_o;
    logic                 stall_o;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [DAT_WIDTH-1:0] m_data;

    int checks = 0;
    int errors = 0;

    wb_fifo_device #(.DAT_WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .rty_o   (rty_o),
        .stall_o (stall_o),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk_i = ~clk_i;

    task automatic test_reset;
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({stall_o, ack_o, err_o, rty_o, m_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got stall/ack/err/rty/mv=%b required 10000",
                     {stall_o, ack_o, err_o, rty_o, m_valid});
        end
        checks++;
        if (dat_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_dat_o: got %h required 00", dat_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_first_cycle: got %b required 1", stall_o);
        end
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_released: got %b required 0", stall_o);
        end
    endtask

    task automatic test_fill;
        logic [7:0] vals [4];
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4;
        m_ready = 1'b0;
        cyc_i   = 1'b1;
        stb_i   = 1'b1;
        we_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat_i = vals[i];
            @(negedge clk_i);
            checks++;
            if ({ack_o, rty_o, err_o} !== 3'b100) begin
                errors++;
                $display("FAIL fill_ack[%0d]: got ack/rty/err=%b required 100", i,
                         {ack_o, rty_o, err_o});
            end
        end
        stb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA1) begin
            errors++;
            $display("FAIL fill_idle: got ack=%b mv=%b md=%h required ack=0 mv=1 md=a1",
                     ack_o, m_valid, m_data);
        end
        stb_i = 1'b1;
        we_i  = 1'b0;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h04) begin
            errors++;
            $display("FAIL fill_level_read: got ack=%b dat_o=%h required ack=1 dat_o=04",
                     ack_o, dat_o);
        end
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || dat_o !== 8'h04) begin
            errors++;
            $display("FAIL dat_o_hold: got ack=%b dat_o=%h required ack=0 dat_o=04",
                     ack_o, dat_o);
        end
    endtask

    task automatic test_full;
        logic exp_err;
        logic exp_rty;
`ifdef WB_DEV_ERR_ON_FULL_EN
        exp_err = 1'b1;
        exp_rty = 1'b0;
`else
        exp_err = 1'b0;
        exp_rty = 1'b1;
`endif
        stb_i = 1'b1;
        we_i  = 1'b1;
        dat_i = 8'h55;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b0 || err_o !== exp_err || rty_o !== exp_rty) begin
            errors++;
            $display("FAIL full_write: got ack=%b err=%b rty=%b required ack=0 err=%b rty=%b",
                     ack_o, err_o, rty_o, exp_err, exp_rty);
        end
        @(negedge clk_i);
        checks++;
        if ({ack_o, err_o, rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL full_pulse_end: got ack/err/rty=%b required 000",
                     {ack_o, err_o, rty_o});
        end
        stb_i = 1'b1;
        we_i  = 1'b0;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h04) begin
            errors++;
            $display("FAIL full_level: got ack=%b dat_o=%h required ack=1 dat_o=04",
                     ack_o, dat_o);
        end
    endtask

    task automatic test_drain;
        logic [7:0] vals [4];
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== vals[i]) begin
                errors++;
                $display("FAIL drain[%0d]: got mv=%b md=%h required mv=1 md=%h", i,
                         m_valid, m_data, vals[i]);
            end
            @(negedge clk_i);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got mv=%b required 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_push_pop;
        stb_i = 1'b1;
        we_i  = 1'b1;
        dat_i = 8'h66;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'h66) begin
            errors++;
            $display("FAIL pp_setup: got ack=%b mv=%b md=%h required ack=1 mv=1 md=66",
                     ack_o, m_valid, m_data);
        end
        m_ready = 1'b1;
        dat_i   = 8'h77;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'h77) begin
            errors++;
            $display("FAIL pp_simul: got ack=%b mv=%b md=%h required ack=1 mv=1 md=77",
                     ack_o, m_valid, m_data);
        end
        we_i = 1'b0;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h01) begin
            errors++;
            $display("FAIL pp_level: got ack=%b dat_o=%h required ack=1 dat_o=01",
                     ack_o, dat_o);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL pp_drained: got mv=%b required 0", m_valid);
        end
        m_ready = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_abort;
        stb_i = 1'b1;
        we_i  = 1'b1;
        dat_i = 8'h3C;
        @(posedge clk_i);
        #1;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_ack: got ack=%b required 0", ack_o);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
            errors++;
            $display("FAIL abort_data: got mv=%b md=%h required mv=1 md=3c", m_valid, m_data);
        end
        cyc_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_ack: got ack=%b required 0", ack_o);
        end
    endtask

    task automatic test_reset_mid;
        stb_i = 1'b1;
        we_i  = 1'b1;
        dat_i = 8'h11;
        rst_i = 1'b0;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if ({stall_o, ack_o, rty_o, err_o, m_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid: got stall/ack/rty/err/mv=%b required 10000",
                     {stall_o, ack_o, rty_o, err_o, m_valid});
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        stb_i = 1'b1;
        we_i  = 1'b0;
        @(negedge clk_i);
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 8'h00 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_level: got ack=%b dat_o=%h mv=%b required ack=1 dat_o=00 mv=0",
                     ack_o, dat_o, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full();
        test_drain();
        test_push_pop();
        test_abort();
        test_reset_mid();
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
